// File: rtl/tmon_sensor_ctrl.sv
// tmon_sensor_ctrl
//   Command-bus consumer for the temperature monitor. Holds the sample-rate
//   (frq_reg) and high-temperature (high_reg) registers, periodically fetches
//   a reading from the sensor front-end over req/ack, and publishes the
//   reading, an over-temperature alarm and a sticky sensor-timeout flag.
//
//   Build option: define TMON_ALARM_LATCH_EN to make alarm sticky (set by any
//   reading above high_reg, cleared only by a RESET op or hard reset).
//
// Ports
//   clk          system clock, all logic on posedge
//   reset        synchronous reset, active low
//   op_valid     command valid
//   op_ready     command can be accepted this cycle
//   op           command code: 0 RESET, 1 NOOP, 2 SET_FRQ, 3 SET_HIGH_TEMP
//   opnd         command operand
//   sens_req     sample request to the sensor front-end
//   sens_ack     sensor data valid (one-cycle pulse)
//   sens_data    sensor reading, qualified by sens_ack
//   temp         last captured reading
//   temp_valid   one-cycle pulse when temp updates
//   alarm        last reading above high threshold
//   timeout_err  sticky sensor-timeout flag
//
// state | meaning
// IDLE  | frq_reg == 0, no sampling
// RUN   | prescaler/tick timer counting toward the next sample
// SENSE | sens_req asserted, waiting for ack or timeout; timer frozen
module tmon_sensor_ctrl #(
  parameter int DW           = 8,
  parameter int PRESCALE     = 16,
  parameter int SENS_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [1:0]    op,
  input  logic [DW-1:0] opnd,
  output logic          sens_req,
  input  logic          sens_ack,
  input  logic [DW-1:0] sens_data,
  output logic [DW-1:0] temp,
  output logic          temp_valid,
  output logic          alarm,
  output logic          timeout_err
);

  localparam logic [1:0] OP_RESET    = 2'd0;
  localparam logic [1:0] OP_SET_FRQ  = 2'd2;
  localparam logic [1:0] OP_SET_HIGH = 2'd3;

  localparam int PW = $clog2(PRESCALE);
  localparam int SW = (SENS_TIMEOUT > 1) ? $clog2(SENS_TIMEOUT) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SENSE_LAST = SW'(SENS_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, SENSE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] frq_q, frq_d;
  logic [DW-1:0] high_q, high_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [DW-1:0] tick_q, tick_d;
  logic [SW-1:0] sense_q, sense_d;
  logic [DW-1:0] temp_q, temp_d;
  logic          tv_q, tv_d;
  logic          alarm_q, alarm_d;
  logic          terr_q, terr_d;
  logic          rdy_q;

  logic          xfer;
  logic          wrap;
  logic          expiry;
  logic          over;
  logic [DW-1:0] frq_m1;

  assign op_ready    = rdy_q && (state_q != SENSE);
  assign sens_req    = (state_q == SENSE);
  assign temp        = temp_q;
  assign temp_valid  = tv_q;
  assign alarm       = alarm_q;
  assign timeout_err = terr_q;

  assign xfer   = op_valid && op_ready;
  assign frq_m1 = frq_q - DW'(1);
  assign wrap   = (pre_q == PRE_LAST);
  assign expiry = (state_q == RUN) && wrap && (tick_q == frq_m1);
  assign over   = (sens_data > high_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      frq_q   <= '0;
      high_q  <= '1;
      pre_q   <= '0;
      tick_q  <= '0;
      sense_q <= '0;
      temp_q  <= '0;
      tv_q    <= 1'b0;
      alarm_q <= 1'b0;
      terr_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frq_q   <= frq_d;
      high_q  <= high_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      sense_q <= sense_d;
      temp_q  <= temp_d;
      tv_q    <= tv_d;
      alarm_q <= alarm_d;
      terr_q  <= terr_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    frq_d   = frq_q;
    high_d  = high_q;
    pre_d   = pre_q;
    tick_d  = tick_q;
    sense_d = sense_q;
    temp_d  = temp_q;
    tv_d    = 1'b0;
    alarm_d = alarm_q;
    terr_d  = terr_q;

    case (state_q)
      IDLE: ;
      RUN: begin
        if (expiry) begin
          state_d = SENSE;
          pre_d   = '0;
          tick_d  = '0;
          sense_d = '0;
        end else if (wrap) begin
          pre_d  = '0;
          tick_d = tick_q + DW'(1);
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      SENSE: begin
        // An ack arriving on the timeout cycle still counts as a good sample.
        if (sens_ack) begin
          temp_d  = sens_data;
          tv_d    = 1'b1;
`ifdef TMON_ALARM_LATCH_EN
          alarm_d = alarm_q | over;
`else
          alarm_d = over;
`endif
          state_d = (frq_q != '0) ? RUN : IDLE;
        end else if (sense_q == SENSE_LAST) begin
          terr_d  = 1'b1;
          state_d = RUN;
        end else begin
          sense_d = sense_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Commands only transfer in IDLE/RUN; SET_FRQ and RESET override a
    // same-cycle expiry, the others let it proceed into SENSE.
    if (xfer) begin
      case (op)
        OP_SET_FRQ: begin
          frq_d   = opnd;
          pre_d   = '0;
          tick_d  = '0;
          state_d = (opnd != '0) ? RUN : IDLE;
        end
        OP_SET_HIGH: high_d = opnd;
        OP_RESET: begin
          state_d = IDLE;
          frq_d   = '0;
          high_d  = '1;
          pre_d   = '0;
          tick_d  = '0;
          sense_d = '0;
          temp_d  = '0;
          tv_d    = 1'b0;
          alarm_d = 1'b0;
          terr_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tmon_sensor_ctrl.sv
module tb_tmon_sensor_ctrl;

  localparam logic [1:0] OP_RESET    = 2'd0;
  localparam logic [1:0] OP_NOOP     = 2'd1;
  localparam logic [1:0] OP_SET_FRQ  = 2'd2;
  localparam logic [1:0] OP_SET_HIGH = 2'd3;

`ifdef TMON_ALARM_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       op_valid;
  logic       op_ready;
  logic [1:0] op;
  logic [7:0] opnd;
  logic       sens_req;
  logic       sens_ack;
  logic [7:0] sens_data;
  logic [7:0] temp;
  logic       temp_valid;
  logic       alarm;
  logic       timeout_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc_cyc;

  // sensor front-end model controls
  bit         ack_en    = 1'b1;
  int         ack_dly   = 2;
  logic [7:0] next_data = 8'h00;
  bit         force_ack = 1'b0;
  logic [7:0] force_data = 8'h00;

  tmon_sensor_ctrl #(.DW(8), .PRESCALE(4), .SENS_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .opnd(opnd), .sens_req(sens_req), .sens_ack(sens_ack),
    .sens_data(sens_data), .temp(temp), .temp_valid(temp_valid),
    .alarm(alarm), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sensor responder: acks ack_dly cycles after sens_req rises.
  initial begin
    int acnt;
    acnt = 0;
    sens_ack = 1'b0;
    sens_data = 8'h00;
    forever begin
      @(negedge clk);
      sens_ack = 1'b0;
      if (force_ack) begin
        sens_ack = 1'b1;
        sens_data = force_data;
      end else if (ack_en && sens_req) begin
        acnt++;
        if (acnt == ack_dly) begin
          sens_ack = 1'b1;
          sens_data = next_data;
        end
      end else begin
        acnt = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] o, input logic [7:0] d);
    int n;
    @(negedge clk);
    op_valid = 1'b1; op = o; opnd = d;
    n = 0;
    while (!op_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", op_ready, 1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    op_valid = 1'b0; op = OP_NOOP; opnd = 8'h00;
  endtask

  task automatic wait_rise(input int limit, output int rc);
    logic seen;
    seen = 1'b0;
    rc = -1;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (sens_req) begin seen = 1'b1; rc = cyc; end
    end
    chk("req_rise_seen", seen, 1);
  endtask

  task automatic wait_tv(input int limit, output int tc);
    logic seen;
    seen = 1'b0;
    tc = -1;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (temp_valid) begin seen = 1'b1; tc = cyc; end
    end
    chk("temp_valid_seen", seen, 1);
  endtask

  task automatic quiet(input int n, input string name);
    int c;
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (sens_req) c++;
    end
    chk(name, c, 0);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] opnd;
    logic [7:0] data;
    logic [7:0] exp_temp;
    logic       exp_alarm;
    int         lat;     // cmd acceptance -> sens_req rise, 0 = unchecked
    int         period;  // previous rise -> this rise, 0 = unchecked
  } vec_t;

  vec_t tbl[9];

  initial begin
    int rc, tc, prev_rc, r, n, tvc, g, k;
    logic prev_alarm;

    tbl[0] = '{OP_SET_FRQ,  8'h03, 8'h40, 8'h40, 1'b0,  12,   0};
    tbl[1] = '{OP_NOOP,     8'h00, 8'h7F, 8'h7F, 1'b0,   0,  14};
    tbl[2] = '{OP_SET_HIGH, 8'h50, 8'h50, 8'h50, 1'b0,   0,  14};
    tbl[3] = '{OP_NOOP,     8'h00, 8'h51, 8'h51, 1'b1,   0,  14};
    tbl[4] = '{OP_NOOP,     8'h00, 8'h30, 8'h30, LATCH,  0,  14};
    tbl[5] = '{OP_SET_HIGH, 8'h20, 8'h20, 8'h20, LATCH,  0,  14};
    tbl[6] = '{OP_SET_FRQ,  8'h01, 8'hFF, 8'hFF, 1'b1,   4,   0};
    tbl[7] = '{OP_SET_HIGH, 8'hFF, 8'hFF, 8'hFF, LATCH,  0,   6};
    tbl[8] = '{OP_SET_FRQ,  8'hFF, 8'h11, 8'h11, LATCH, 1020, 0};

    reset = 1'b0; op_valid = 1'b0; op = OP_NOOP; opnd = 8'h00;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_op_ready", op_ready, 0);
    chk("rst_sens_req", sens_req, 0);
    chk("rst_temp", temp, 0);
    chk("rst_temp_valid", temp_valid, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_timeout_err", timeout_err, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_op_ready", op_ready, 1);
    chk("rel_sens_req", sens_req, 0);
    chk("rel_temp", temp, 0);
    quiet(100, "idle_no_req");

    // table-driven sampling
    prev_rc = 0;
    prev_alarm = 1'b0;
    for (int i = 0; i < 9; i++) begin
      next_data = tbl[i].data;
      send(tbl[i].op, tbl[i].opnd);
      chk($sformatf("v%0d_alarm_hold", i), alarm, prev_alarm);
      wait_rise(1200, rc);
      if (tbl[i].lat != 0) chk($sformatf("v%0d_req_latency", i), rc - acc_cyc, tbl[i].lat);
      if (tbl[i].period != 0) chk($sformatf("v%0d_period", i), rc - prev_rc, tbl[i].period);
      wait_tv(20, tc);
      chk($sformatf("v%0d_ack_to_tv", i), tc - rc, 2);
      chk($sformatf("v%0d_temp", i), temp, tbl[i].exp_temp);
      chk($sformatf("v%0d_alarm", i), alarm, tbl[i].exp_alarm);
      chk($sformatf("v%0d_req_drop", i), sens_req, 0);
      @(negedge clk);
      chk($sformatf("v%0d_tv_pulse", i), temp_valid, 0);
      prev_rc = rc;
      prev_alarm = tbl[i].exp_alarm;
    end

    // sensor timeout, then resume, then RESET op clears
    ack_en = 1'b0;
    send(OP_SET_FRQ, 8'h02);
    wait_rise(50, r);
    chk("to_latency", r - acc_cyc, 8);
    n = 1; tvc = 0;
    while (sens_req && n < 50) begin
      @(negedge clk);
      if (sens_req) n++;
      if (temp_valid) tvc++;
    end
    chk("to_req_cycles", n, 8);
    chk("to_err_set", timeout_err, 1);
    chk("to_temp_kept", temp, 8'h11);
    chk("to_no_tv", tvc, 0);
    ack_en = 1'b1;
    next_data = 8'h22;
    wait_rise(50, rc);
    chk("to_resume_period", rc - r, 16);
    wait_tv(20, tc);
    chk("to_resume_temp", temp, 8'h22);
    chk("to_err_sticky", timeout_err, 1);
    send(OP_RESET, 8'h00);
    chk("rop_timeout_err", timeout_err, 0);
    chk("rop_temp", temp, 0);
    chk("rop_alarm", alarm, 0);
    chk("rop_op_ready", op_ready, 1);
    quiet(40, "rop_idle_no_req");

    // ack outside SENSE is ignored
    force_data = 8'h99;
    @(posedge clk); #1 force_ack = 1'b1;
    @(posedge clk); #1 force_ack = 1'b0;
    chk("stray_ack_temp", temp, 0);
    chk("stray_ack_tv", temp_valid, 0);
    chk("stray_ack_req", sens_req, 0);

    // ack on the timeout cycle wins
    ack_dly = 8;
    next_data = 8'h66;
    send(OP_SET_FRQ, 8'h01);
    wait_rise(50, rc);
    wait_tv(20, tc);
    chk("ackto_delay", tc - rc, 8);
    chk("ackto_temp", temp, 8'h66);
    chk("ackto_no_err", timeout_err, 0);

    // command held during SENSE
    ack_dly = 2;
    next_data = 8'h05;
    wait_rise(50, rc);
    op_valid = 1'b1; op = OP_SET_FRQ; opnd = 8'h05;
    chk("sense_op_ready", op_ready, 0);
    k = 0;
    while (!op_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("sense_wait_cycles", k, 2);
    chk("sense_first_run_tv", temp_valid, 1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    op_valid = 1'b0; op = OP_NOOP; opnd = 8'h00;
    wait_rise(50, r);
    chk("frq5_latency", r - acc_cyc, 20);
    wait_tv(20, tc);

    // SET_HIGH_TEMP on the expiry cycle: SENSE still entered, new threshold used
    next_data = 8'h20;
    g = 0;
    while (cyc != r + 21 && g < 100) begin
      @(negedge clk);
      g++;
    end
    op_valid = 1'b1; op = OP_SET_HIGH; opnd = 8'h10;
    chk("exp_high_ready", op_ready, 1);
    @(posedge clk); #1;
    op_valid = 1'b0; op = OP_NOOP; opnd = 8'h00;
    wait_rise(10, rc);
    chk("exp_high_rise", rc - r, 22);
    wait_tv(20, tc);
    chk("exp_high_alarm", alarm, 1);
    chk("exp_high_temp", temp, 8'h20);

    // SET_FRQ 0 on the expiry cycle cancels the sample
    g = 0;
    while (cyc != rc + 21 && g < 100) begin
      @(negedge clk);
      g++;
    end
    op_valid = 1'b1; op = OP_SET_FRQ; opnd = 8'h00;
    chk("exp_frq0_ready", op_ready, 1);
    @(posedge clk); #1;
    op_valid = 1'b0; op = OP_NOOP; opnd = 8'h00;
    quiet(60, "exp_frq0_no_req");

    // hard reset in the middle of SENSE
    ack_en = 1'b0;
    send(OP_SET_FRQ, 8'h01);
    wait_rise(50, rc);
    @(negedge clk);
    chk("hrst_pre_req", sens_req, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("hrst_req_drop", sens_req, 0);
    chk("hrst_op_ready", op_ready, 0);
    chk("hrst_alarm", alarm, 0);
    chk("hrst_temp", temp, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("hrst_rel_ready", op_ready, 1);
    chk("hrst_timeout_err", timeout_err, 0);
    quiet(40, "hrst_frq0_no_req");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
